// File: rtl/arbiter_n2_client.sv
// Multi-channel arbiter client: each channel queues job lengths, requests the
// shared arbiter, and emits one beat per grant until every queued job is drained.
module arbiter_n2_client #(
    parameter int N      = 2,
    parameter int LEN_W  = 4,
    parameter int QDEPTH = 4,
    parameter int TMO    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N-1:0]                       job_valid,
    input  logic [N*LEN_W-1:0]                 job_len,
    output logic [N-1:0]                       job_ready,
    output logic [N-1:0]                       req,
    input  logic [N-1:0]                       gnt,
    output logic [N-1:0]                       beat,
    output logic [N-1:0]                       done,
    output logic [N-1:0]                       starve,
    output logic [N*$clog2(QDEPTH+1)-1:0]      pend_cnt,
    output logic                               err
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int WW = $clog2(TMO + 1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    logic err_q, err_d;
    logic multi_gnt, stray_gnt;

    // A grant is an error if it targets an idle channel or is not one-hot.
    assign multi_gnt = |(gnt & (gnt - N'(1)));
    assign stray_gnt = |(gnt & ~req);
    assign err_d     = err_q | multi_gnt | stray_gnt;
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    genvar i;
    for (i = 0; i < N; i++) begin : g_ch
        state_t            state_q, state_d;
        logic [LEN_W-1:0]  mem_q [QDEPTH];
        logic [LEN_W-1:0]  mem_d [QDEPTH];
        logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
        logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
        logic [AW-1:0]     rd_next;
        logic [CW-1:0]     count_q, count_d;
        logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
        logic [WW-1:0]     wait_q, wait_d;
        logic [LEN_W-1:0]  push_len;
        logic              push, pop, granted;

        assign push_len     = job_len[i*LEN_W +: LEN_W];
        assign job_ready[i] = (count_q != CW'(QDEPTH));
        assign push         = job_valid[i] & job_ready[i];
        assign req[i]       = (state_q == REQ);
        assign granted      = req[i] & gnt[i];
        assign beat[i]      = granted;
        assign pop          = granted & (beat_cnt_q == '0);
        assign done[i]      = pop;
        assign starve[i]    = (wait_q == WW'(TMO));
        assign rd_next      = rd_ptr_q + AW'(1);
        assign pend_cnt[i*CW +: CW] = count_q;

        always_comb begin
            mem_d      = mem_q;
            wr_ptr_d   = wr_ptr_q;
            rd_ptr_d   = rd_ptr_q;
            count_d    = count_q;
            state_d    = state_q;
            beat_cnt_d = beat_cnt_q;
            wait_d     = wait_q;

            if (push) begin
                mem_d[wr_ptr_q] = push_len;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_next;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            case (state_q)
                IDLE: begin
                    wait_d = '0;
                    if (count_q != '0) begin
                        state_d    = REQ;
                        beat_cnt_d = mem_q[rd_ptr_q];
                    end
                end
                REQ: begin
                    if (granted) begin
                        wait_d = '0;
                        if (pop) begin
                            // A job pushed while the last one finishes is taken over directly.
                            if (count_q > CW'(1)) begin
                                beat_cnt_d = mem_q[rd_next];
                            end else if (push) begin
                                beat_cnt_d = push_len;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            beat_cnt_d = beat_cnt_q - LEN_W'(1);
                        end
                    end else if (wait_q != WW'(TMO)) begin
                        wait_d = wait_q + WW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q    <= IDLE;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                beat_cnt_q <= '0;
                wait_q     <= '0;
                for (int k = 0; k < QDEPTH; k++) begin
                    mem_q[k] <= '0;
                end
            end else begin
                state_q    <= state_d;
                wr_ptr_q   <= wr_ptr_d;
                rd_ptr_q   <= rd_ptr_d;
                count_q    <= count_d;
                beat_cnt_q <= beat_cnt_d;
                wait_q     <= wait_d;
                mem_q      <= mem_d;
            end
        end
    end

endmodule
